// File: rtl/uart_rx_word_ctrl_if.sv
// Handshake bundle between the word sequencer, the UART receiver and the
// word consumer. The sequencer side is the master modport.
interface uart_rx_word_ctrl_if #(
  parameter int BIT   = 8,
  parameter int BYTES = 4
);
  logic                 rx_start;
  logic                 rx_ready;
  logic [BIT-1:0]       rx_data;
  logic [BIT*BYTES-1:0] word_data;
  logic                 word_valid;
  logic                 word_ready;

  modport master (
    output rx_start, word_data, word_valid,
    input  rx_ready, rx_data, word_ready
  );

  modport slave (
    input  rx_start, word_data, word_valid,
    output rx_ready, rx_data, word_ready
  );
endinterface

// File: rtl/uart_rx_word_ctrl.sv
// Arms the UART receiver one byte at a time, packs BYTES bytes into a word
// (first byte in the LSBs), offers it on valid/ready and drops partial words
// after an inter-byte timeout so the stream can resynchronise.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | parked; waits for en at a word boundary
// S_ARM   | one-cycle rx_start pulse to the receiver
// S_WAIT  | receiver armed; waiting for rx_ready, inter-byte timer runs
// S_DRAIN | waiting for rx_ready to fall before re-arming
// S_OUT   | word presented; held until the consumer accepts it
module uart_rx_word_ctrl #(
  parameter int BIT     = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 8000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  uart_rx_word_ctrl_if.master bus,
  output logic                err_timeout,
  output logic                busy
);

  localparam int            IW       = $clog2(BYTES) + 1;
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN    = (TIMEOUT > 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_DRAIN, S_OUT} state_t;

  state_t        state, state_next;
  logic [IW-1:0] byte_idx, idx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          capture;
  logic          expire;

  // Next-state, byte index and inter-byte timer; the timer defaults to
  // clear so it only holds a count while waiting for a non-first byte.
  always_comb begin
    state_next = state;
    idx_next   = byte_idx;
    cnt_next   = '0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_next = S_ARM;
      end
      S_ARM: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rx_ready) begin
          // A byte arriving on the expiry cycle still counts.
          capture = 1'b1;
          if (byte_idx == LAST_IDX) begin
            state_next = S_OUT;
          end else begin
            idx_next   = byte_idx + IW'(1);
            state_next = S_DRAIN;
          end
        end else if (TO_EN && byte_idx != '0) begin
          if (cnt == CNT_LAST) begin
            // Receiver stays armed; its next byte starts a fresh word.
            expire   = 1'b1;
            idx_next = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!bus.rx_ready) begin
          if (byte_idx != '0 || en) state_next = S_ARM;
          else                      state_next = S_IDLE;
        end
      end
      S_OUT: begin
        if (bus.word_ready) begin
          idx_next   = '0;
          state_next = S_DRAIN;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      byte_idx       <= '0;
      cnt            <= '0;
      bus.rx_start   <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.word_data  <= '0;
      err_timeout    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      byte_idx       <= idx_next;
      cnt            <= cnt_next;
      bus.rx_start   <= (state_next == S_ARM);
      bus.word_valid <= (state_next == S_OUT);
      err_timeout    <= expire;
      busy           <= (state_next != S_IDLE);
      if (capture) begin
        for (int i = 0; i < BYTES; i++) begin
          if (byte_idx == IW'(i)) bus.word_data[i*BIT +: BIT] <= bus.rx_data;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_word_ctrl.md
Name: uart_rx_word_ctrl

Overview:
- Sequencer placed in front of the UART receiver (`uart_rx`). It arms the receiver one byte at a time and assembles BYTES consecutive bytes into one word, first byte in the LSBs.
- Presents the word to the consumer on a valid/ready handshake.
- Applies an inter-byte timeout that discards partial words so the stream resynchronises.
- Sits between `uart_rx` and the command/loader logic that consumes multi-byte words.

Parameters:
- BIT, 8, receiver word size in bits (matches the receiver).
- BYTES, 4, receiver words per assembled word; legal range 1..8.
- TIMEOUT, 8000, max clk cycles spent waiting for byte k (k>0) of a word; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high. The integrator drives the receiver's rst_n from ~rst.
- en  in  1  when high, the block may start a new word. Sampled only in IDLE.
- rx_start  out  1  one-cycle arm pulse, connects to receiver rx_data_start.
- rx_ready  in  1  receiver rx_data_ready (level).
- rx_data  in  BIT  receiver rx_data.
- word_data  out  BIT*BYTES  assembled word; byte i is at bits [i*BIT +: BIT].
- word_valid  out  1  word_data valid; held until accepted.
- word_ready  in  1  consumer accept.
- err_timeout  out  1  one-cycle pulse when a partial word is discarded.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, rx_start=0, word_valid=0, word_data=0, err_timeout=0, byte index=0, timeout counter=0. Reset overrides all events in the same cycle, including mid-word and mid-handshake.
- All outputs are registered.
- States:
  - IDLE: if en, go to ARM; otherwise stay.
  - ARM: rx_start=1 for exactly this one cycle, then go to WAIT.
  - WAIT: on rx_ready=1, capture rx_data into slot byte_idx.
    - If byte_idx==BYTES-1, go to OUT; word_valid=1 in the next cycle.
    - Otherwise byte_idx++ and go to DRAIN.
  - DRAIN: wait for rx_ready=0 (receiver back in its idle state).
    - Then go to ARM if byte_idx>0; if byte_idx==0, go to ARM when en=1, else IDLE.
  - OUT: word_valid=1 and word_data stable. On word_valid&&word_ready: word_valid=0, byte_idx=0, go to DRAIN. No rx_start is issued while in OUT (backpressure).
- Capture latency: the last byte is captured at the first posedge with rx_ready=1 in WAIT; word_valid rises on the following cycle.
- Timeout:
  - The counter runs only in WAIT with byte_idx>0; it clears on any capture and on leaving WAIT.
  - When the counter reaches TIMEOUT-1: err_timeout pulses for 1 cycle, byte_idx=0, the counter clears, and the state stays WAIT. The receiver is still armed; its next byte becomes byte 0 of a new word.
  - If a capture and the expiry fall in the same cycle, the capture wins: no error, the counter clears.
  - WAIT with byte_idx==0 never times out.
- en is only consulted at word boundaries (IDLE, or DRAIN with byte_idx==0). Deasserting en mid-word does not abort the word.
- Slots not yet written in the current word keep their previous values. word_data is only meaningful while word_valid=1.
- byte_idx width is clog2(BYTES)+1; the timeout counter width is clog2(TIMEOUT+1).
- BYTES=1: every capture goes directly to OUT; the timeout is never active.

Test Plan:
- Reset, en=1, receiver delivers 0x11,0x22,0x33,0x44 → exactly 4 rx_start pulses; word_valid rises 1 cycle after the 4th capture with word_data=0x44332211; no err_timeout.
- Same stream with word_ready held low 200 cycles after valid → word_data stays 0x44332211, word_valid stays high, no rx_start until 1 cycle after accept plus rx_ready low.
- TIMEOUT=50: bytes 0xAA,0xBB, then silence 60 cycles, then 0x01,0x02,0x03,0x04 → single err_timeout pulse exactly 50 cycles after entering WAIT for byte 2; next word=0x04030201.
- en=0 from reset for 100 cycles → rx_start never asserted, busy=0. Raise en → rx_start pulses on the 2nd cycle after en is sampled.
- Assert rst for 1 cycle after the 2nd byte of a word → all outputs reset values next cycle. A subsequent 4-byte stream 0x10,0x20,0x30,0x40 yields 0x40302010.
- BYTES=1, bytes 0x5A,0xA5 with word_ready=1 → two words 0x5A then 0xA5, each word_valid exactly 1 cycle.
